// File: rtl/lanes_pkg.sv
// rtl/lanes_pkg.sv - shared encodings, periods and state type for the lane serializer sequencer
package lanes_pkg;

  // Generation speed encodings; 2'b11 falls back to GEN4
  localparam logic [1:0] GEN4 = 2'b00;
  localparam logic [1:0] GEN3 = 2'b01;
  localparam logic [1:0] GEN2 = 2'b10;

  // Serializer load period, in clocks, per generation
  localparam int PERIOD_GEN4 = 8;
  localparam int PERIOD_GEN3 = 132;
  localparam int PERIOD_GEN2 = 66;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRELOAD = 2'd1,
    RUN     = 2'd2,
    DRAIN   = 2'd3
  } state_t;

  // Load period for a generation code; the unused code behaves as GEN4
  function automatic logic [7:0] gen_period(input logic [1:0] gen_speed);
    case (gen_speed)
      GEN3:    gen_period = 8'(PERIOD_GEN3);
      GEN2:    gen_period = 8'(PERIOD_GEN2);
      default: gen_period = 8'(PERIOD_GEN4);
    endcase
  endfunction

endpackage

// File: rtl/lanes_ser_period_cnt.sv
// rtl/lanes_ser_period_cnt.sv - latched-period counter producing the serializer load instant
module lanes_ser_period_cnt
  import lanes_pkg::*;
#(
  parameter int WIDTH = 132,
  localparam int CW   = $clog2(WIDTH)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       latch,
  input  logic [1:0] gen_speed,
  input  logic       enable,
  input  logic       preset,
  output logic       load_strobe
);

  logic [CW-1:0] period_m1;
  logic [CW-1:0] cnt;

  // The strobe marks the last clock of each period while shifting is enabled
  assign load_strobe = enable && (cnt == period_m1);

  // Capture period-1 once per session so a speed change while busy has no effect
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      period_m1 <= CW'(PERIOD_GEN4 - 1);
    end else if (latch) begin
      period_m1 <= CW'(gen_period(gen_speed) - 8'd1);
    end
  end

  // Preset parks the counter on the strobe value so the first enabled clock loads
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (preset) begin
      cnt <= period_m1;
    end else if (load_strobe) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/lanes_ser_ctrl.sv
// rtl/lanes_ser_ctrl.sv - sequencer feeding and gating the dual-lane TX serializer
module lanes_ser_ctrl
  import lanes_pkg::*;
#(
  parameter int               WIDTH     = 132,
  parameter logic [WIDTH-1:0] IDLE_WORD = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tx_en,
  input  logic [1:0]       gen_speed,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_lane_0_data,
  input  logic [WIDTH-1:0] in_lane_1_data,
  input  logic             ser_word_taken,
  output logic             enable_ser,
  output logic [WIDTH-1:0] lane_0_tx_parallel,
  output logic [WIDTH-1:0] lane_1_tx_parallel,
  output logic             busy,
  output logic [15:0]      underrun_cnt,
  output logic             sync_err
);

  state_t state;
  logic   buf_full;
  logic   load_strobe;
  logic   strobe_d;
  logic   xfer;
  logic   drain_done;

  // A word may enter while the buffer is empty or is being emptied this very clock
  assign in_ready   = ((state == PRELOAD) || (state == RUN)) && (!buf_full || load_strobe);
  assign xfer       = in_valid && in_ready;
  assign busy       = (state != IDLE);
  assign drain_done = (state == DRAIN) && load_strobe && !buf_full;

  lanes_ser_period_cnt #(.WIDTH(WIDTH)) u_period_cnt (
    .clk         (clk),
    .rst         (rst),
    .latch       ((state == IDLE) && tx_en),
    .gen_speed   (gen_speed),
    .enable      (enable_ser),
    .preset      ((state == PRELOAD) && tx_en && buf_full),
    .load_strobe (load_strobe)
  );

  // Sequencer state, output word register, underrun count and load-pulse cross-check
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state              <= IDLE;
      buf_full           <= 1'b0;
      enable_ser         <= 1'b0;
      lane_0_tx_parallel <= IDLE_WORD;
      lane_1_tx_parallel <= IDLE_WORD;
      underrun_cnt       <= '0;
      sync_err           <= 1'b0;
      strobe_d           <= 1'b0;
    end else begin
      // The final drain strobe is swallowed by the disable, so no pulse is expected after it
      strobe_d <= load_strobe && !drain_done;
      if (ser_word_taken != strobe_d) begin
        sync_err <= 1'b1;
      end

      // The serializer samples the old word at this edge, so a new word may land alongside
      if (xfer) begin
        lane_0_tx_parallel <= in_lane_0_data;
        lane_1_tx_parallel <= in_lane_1_data;
        buf_full           <= 1'b1;
      end else if (load_strobe) begin
        lane_0_tx_parallel <= IDLE_WORD;
        lane_1_tx_parallel <= IDLE_WORD;
        buf_full           <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (tx_en) begin
            state    <= PRELOAD;
            sync_err <= 1'b0;
          end
        end
        PRELOAD: begin
          if (!tx_en) begin
            state              <= IDLE;
            lane_0_tx_parallel <= IDLE_WORD;
            lane_1_tx_parallel <= IDLE_WORD;
            buf_full           <= 1'b0;
          end else if (buf_full) begin
            state      <= RUN;
            enable_ser <= 1'b1;
          end
        end
        RUN: begin
          if (load_strobe && !buf_full && (underrun_cnt != 16'hFFFF)) begin
            underrun_cnt <= underrun_cnt + 16'd1;
          end
          if (!tx_en) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (drain_done) begin
            state      <= IDLE;
            enable_ser <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lanes_ser_ctrl.sv
// tb/tb_lanes_ser_ctrl.sv - self-checking bench for lanes_ser_ctrl with a serializer model and scoreboard
module tb_lanes_ser_ctrl;

  localparam int W  = 132;
  localparam int PW = 2 * W;
  localparam logic [PW-1:0] IDLE_PAIR = '0;

  typedef struct {
    logic [1:0]  gen;
    int          n;
    int          gap;
    logic        delay;
    logic [15:0] exp_under;
    int          exp_period;
    logic        exp_sync;
  } vec_t;

  typedef struct {
    logic [PW-1:0] act;
    logic [PW-1:0] exp;
  } res_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          tx_en = 1'b0;
  logic [1:0]    gen_speed = 2'b00;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_lane_0_data = '0;
  logic [W-1:0]  in_lane_1_data = '0;
  logic          ser_word_taken;
  logic          enable_ser;
  logic [W-1:0]  lane_0_tx_parallel;
  logic [W-1:0]  lane_1_tx_parallel;
  logic          busy;
  logic [15:0]   underrun_cnt;
  logic          sync_err;

  logic          delay_mode = 1'b0;
  logic          ser_load;
  logic          scr_q;
  logic          scr_q2;

  int            n_cmp = 0;
  int            n_fail = 0;

  logic [PW-1:0] sb[$];
  res_t          res_q[$];
  int            xfer_t[$];
  int            cyc = 0;
  logic          pend_valid = 1'b0;
  logic          pend_has = 1'b0;
  logic [PW-1:0] pend_word = '0;
  logic [PW-1:0] pend_exp = '0;
  int            words_loaded = 0;
  int            idle_loaded = 0;

  vec_t          vecs[6];

  lanes_ser_ctrl #(.WIDTH(W)) dut (
    .clk                (clk),
    .rst                (rst),
    .tx_en              (tx_en),
    .gen_speed          (gen_speed),
    .in_valid           (in_valid),
    .in_ready           (in_ready),
    .in_lane_0_data     (in_lane_0_data),
    .in_lane_1_data     (in_lane_1_data),
    .ser_word_taken     (ser_word_taken),
    .enable_ser         (enable_ser),
    .lane_0_tx_parallel (lane_0_tx_parallel),
    .lane_1_tx_parallel (lane_1_tx_parallel),
    .busy               (busy),
    .underrun_cnt       (underrun_cnt),
    .sync_err           (sync_err)
  );

  always #5 clk = ~clk;

  // Serializer model: parked on its load value while disabled, loads on the first enabled clock
  lanes_ser_period_cnt #(.WIDTH(W)) u_ser_cnt (
    .clk         (clk),
    .rst         (rst),
    .latch       (!enable_ser),
    .gen_speed   (gen_speed),
    .enable      (enable_ser),
    .preset      (!enable_ser),
    .load_strobe (ser_load)
  );

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      scr_q  <= 1'b0;
      scr_q2 <= 1'b0;
    end else begin
      scr_q  <= ser_load;
      scr_q2 <= scr_q;
    end
  end

  assign ser_word_taken = enable_ser & (delay_mode ? scr_q2 : scr_q);

  // Scoreboard: transfers push expected pairs, serializer loads pop them; a load only counts if enable survives it
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (!rst) begin
      sb.delete();
      res_q.delete();
      xfer_t.delete();
      pend_valid   = 1'b0;
      words_loaded = 0;
      idle_loaded  = 0;
    end else begin
      if (pend_valid) begin
        pend_valid = 1'b0;
        if (enable_ser) begin
          if (pend_has) begin
            res_q.push_back('{pend_word, pend_exp});
            words_loaded = words_loaded + 1;
          end else begin
            res_q.push_back('{pend_word, IDLE_PAIR});
            idle_loaded = idle_loaded + 1;
          end
        end
      end
      if (ser_load) begin
        pend_valid = 1'b1;
        pend_word  = {lane_0_tx_parallel, lane_1_tx_parallel};
        pend_has   = (sb.size() > 0);
        if (pend_has) pend_exp = sb.pop_front();
      end
      if (in_valid && in_ready) begin
        sb.push_back({in_lane_0_data, in_lane_1_data});
        xfer_t.push_back(cyc);
      end
    end
  end

  task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_reset_outputs();
    chk("rst_enable_ser", PW'(enable_ser), PW'(0));
    chk("rst_lanes", {lane_0_tx_parallel, lane_1_tx_parallel}, IDLE_PAIR);
    chk("rst_in_ready", PW'(in_ready), PW'(0));
    chk("rst_busy", PW'(busy), PW'(0));
    chk("rst_underrun", PW'(underrun_cnt), PW'(0));
    chk("rst_sync_err", PW'(sync_err), PW'(0));
  endtask

  task automatic do_reset();
    tx_en    = 1'b0;
    in_valid = 1'b0;
    rst      = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic run_scen(input vec_t v, input int s);
    logic ok;
    int   bound;
    do_reset();
    gen_speed  = v.gen;
    delay_mode = v.delay;
    tx_en      = 1'b1;
    for (int i = 0; i < v.n; i++) begin
      if (i == 1) repeat (v.gap) @(posedge clk);
      if (i == 1 && v.gap > 0) #1;
      in_lane_0_data = W'(s * 16 + i + 1);
      in_lane_1_data = W'(32'hA500 + s * 16 + i + 1);
      in_valid = 1'b1;
      ok = 1'b0;
      for (int c = 0; c < 400 && !ok; c++) begin
        ok = in_ready;
        @(posedge clk);
        #1;
      end
      in_valid = 1'b0;
      chk("xfer_done", PW'(ok), PW'(1));
      if (i == 0) begin
        chk("en_pre", PW'(enable_ser), PW'(0));
        @(posedge clk);
        #1;
        chk("en_rise", PW'(enable_ser), PW'(1));
      end
    end
    tx_en = 1'b0;
    bound = 4 * v.exp_period + 20;
    for (int c = 0; c < bound && busy; c++) begin
      @(posedge clk);
      #1;
    end
    chk("busy_end", PW'(busy), PW'(0));
    chk("en_fall", PW'(enable_ser), PW'(0));
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < res_q.size(); i++) chk("word", res_q[i].act, res_q[i].exp);
    chk("words_loaded", PW'(words_loaded), PW'(v.n));
    chk("idle_loaded", PW'(idle_loaded), PW'(v.exp_under));
    chk("underrun_cnt", PW'(underrun_cnt), PW'(v.exp_under));
    chk("sb_empty", PW'(sb.size()), PW'(0));
    chk("sync_err", PW'(sync_err), PW'(v.exp_sync));
    if (xfer_t.size() >= 2)
      chk("period", PW'(xfer_t[xfer_t.size()-1] - xfer_t[xfer_t.size()-2]), PW'(v.exp_period));
    else
      chk("xfer_count", PW'(xfer_t.size()), PW'(v.n));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic ok;
    //          gen    n   gap  dly under period sync
    vecs[0] = '{2'b00, 3,  0,   0,  0,    8,     0};
    vecs[1] = '{2'b01, 4,  198, 0,  1,    132,   0};
    vecs[2] = '{2'b10, 10, 0,   0,  0,    66,    0};
    vecs[3] = '{2'b11, 4,  12,  0,  1,    8,     0};
    vecs[4] = '{2'b00, 3,  0,   1,  0,    8,     1};
    vecs[5] = '{2'b11, 3,  0,   0,  0,    8,     0};

    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs();
    rst = 1'b1;
    @(posedge clk);
    #1;

    for (int s = 0; s < 5; s++) run_scen(vecs[s], s);

    // Sticky sync error survives into IDLE and clears on the next session start
    delay_mode = 1'b0;
    chk("sync_held", PW'(sync_err), PW'(1));
    tx_en = 1'b1;
    @(posedge clk);
    #1;
    chk("sync_clear", PW'(sync_err), PW'(0));
    chk("preload_busy", PW'(busy), PW'(1));
    tx_en = 1'b0;
    @(posedge clk);
    #1;
    chk("preload_abort", PW'(busy), PW'(0));

    // Asynchronous reset mid-RUN at GEN3, after one underrun, with cnt at 40
    do_reset();
    gen_speed      = 2'b01;
    tx_en          = 1'b1;
    in_lane_0_data = W'(32'h77);
    in_lane_1_data = W'(32'h88);
    in_valid       = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    for (int c = 0; c < 20 && !enable_ser; c++) begin
      @(posedge clk);
      #1;
    end
    chk("run_en", PW'(enable_ser), PW'(1));
    repeat (173) @(posedge clk);
    #1;
    chk("pre_rst_under", PW'(underrun_cnt), PW'(1));
    chk("pre_rst_busy", PW'(busy), PW'(1));
    #2 rst = 1'b0;
    #1;
    chk_reset_outputs();
    tx_en = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_busy", PW'(busy), PW'(0));
    chk("post_rst_under", PW'(underrun_cnt), PW'(0));

    run_scen(vecs[5], 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/lanes_ser_ctrl.md
Name: lanes_ser_ctrl

Overview:
Sequencer that feeds and gates the dual-lane TX serializer. It accepts parallel word pairs from upstream over a valid/ready handshake and presents them on the serializer's parallel inputs. It drives enable_ser, keeping its own copy of the serializer's load instant for the latched generation speed. It inserts idle words on underrun, drains cleanly on stop, and cross-checks the serializer's load pulse (scr_rst) for loss of sync.

Parameters:
WIDTH, 132, parallel word width per lane; must match the serializer.
IDLE_WORD, {WIDTH{1'b0}}, pattern presented when no upstream word is buffered.

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-low
tx_en  in  1  level request to transmit; sampled every cycle
gen_speed  in  2  00=GEN4 (period 8), 01=GEN3 (132), 10=GEN2 (66), 11 treated as GEN4
in_valid  in  1  upstream word pair valid
in_ready  out  1  block can accept a word pair; transfer = in_valid & in_ready
in_lane_0_data  in  WIDTH  upstream lane 0 word
in_lane_1_data  in  WIDTH  upstream lane 1 word
ser_word_taken  in  1  serializer scr_rst; one-cycle pulse after each serializer load
enable_ser  out  1  serializer enable (registered)
lane_0_tx_parallel  out  WIDTH  word presented to serializer lane 0 (registered)
lane_1_tx_parallel  out  WIDTH  word presented to serializer lane 1 (registered)
busy  out  1  state != IDLE
underrun_cnt  out  16  saturating count of idle words inserted while in RUN
sync_err  out  1  sticky; ser_word_taken mismatched the expected load instant

Behaviour:
- Reset values: enable_ser=0, lane_*_tx_parallel=IDLE_WORD, in_ready=0, busy=0, underrun_cnt=0, sync_err=0, buf_full=0, state=IDLE. Reset mid-operation aborts immediately; no drain.
- in_ready is combinational: (state==PRELOAD | RUN) & (!buf_full | load_strobe).
- Internal period counter cnt ($clog2(WIDTH) bits); load_strobe = enable_ser & (cnt==period-1). On load_strobe cnt wraps to 0; otherwise it increments while enable_ser=1.
- Period is latched from gen_speed on IDLE->PRELOAD. A gen_speed change while busy is ignored.
- Output register write: a transfer writes both lane words and sets buf_full. Otherwise, a load_strobe writes IDLE_WORD and clears buf_full. A transfer coinciding with load_strobe is legal: the serializer samples the old word and the new word is written at the same edge, so buf_full stays 1.
- FSM transitions:
  - IDLE: tx_en=1 -> PRELOAD; clear sync_err.
  - PRELOAD: tx_en=0 -> IDLE, and any buffered word is dropped to IDLE_WORD. buf_full=1 -> RUN, with enable_ser<=1 and cnt<=period-1 at the same edge. This makes load_strobe true in the first RUN cycle, matching the serializer's first-cycle load.
  - RUN: a load_strobe with buf_full=0 (idle word loaded) increments underrun_cnt, saturating at 16'hFFFF. tx_en=0 -> DRAIN.
  - DRAIN: in_ready=0; buffered words continue to be loaded. The first load_strobe with buf_full=0 -> IDLE with enable_ser<=0 at that edge; this strobe does not count as an underrun. The serializer clears on the disable, so the idle word is never shifted. tx_en=1 in DRAIN is ignored until IDLE is reached.
- Latency: first data bit appears on the serial lane 2 cycles after the PRELOAD->RUN edge. Upstream word pair n is loaded at the n-th load_strobe.
- Sync check: ser_word_taken is expected exactly 1 cycle after each load_strobe, and only then. Any missing or extra pulse sets sync_err, which holds until reset or the next IDLE->PRELOAD.
- GEN4: only bits [7:0] are serialized; upper bits are don't-care.

Decomposition:
- Shared package lanes_pkg:
  - gen_speed encodings GEN4/GEN3/GEN2
  - period constants 8/132/66
  - state enum IDLE/PRELOAD/RUN/DRAIN
  - function gen_period(gen_speed)
- One sub-module, lanes_ser_period_cnt: latches the period and produces cnt and load_strobe. The serializer model in the bench reuses it.

Test Plan:
- GEN4, tx_en=1, upstream always valid with words 0x01,0x02,0x03 per lane -> enable_ser rises 1 cycle after first transfer; load_strobe every 8 cycles; serial output LSB-first shows 01,02,03; underrun_cnt=0; sync_err=0.
- GEN3 (period 132), in_valid withheld for one period after the first word -> one IDLE_WORD serialized; underrun_cnt=1; next valid word sent at the following strobe.
- GEN2, transfer issued in the same cycle as load_strobe -> old word serialized, new word kept, buf_full remains 1, no word lost or duplicated over 10 words.
- tx_en dropped mid-word with one word buffered -> current and buffered words fully serialized; enable_ser falls on the next strobe with buf_full=0; busy=0 one cycle later; underrun_cnt unchanged.
- Serializer model delayed by 1 cycle, so ser_word_taken lands 2 cycles after load_strobe -> sync_err=1 and held; it clears on the next IDLE->PRELOAD.
- rst asserted during RUN (GEN3, cnt=40) -> all outputs to reset values asynchronously; after release, IDLE with underrun_cnt=0. gen_speed=11 then behaves as GEN4 (period 8).
